mod_hs_packet_framer: RTL
=========================

// Module: mod_hs_packet_framer
// PURPOSE
//  Parametrised packet framer for the high-speed serial link.
//  On a start strobe it emits a frame as a byte stream: marker, flag, length field, payload from RAM, optional CRC16.
//  It sits between the packet RAM (req/rdy read port) and the serial line coder (byte valid/ready port).
//  Compared with the fixed coder, it adds configurable widths, a base address, abort, RAM-timeout error and DONE/ERR status.
// PARAMETERS
//  ADDR_W       16     RAM address width
//  LEN_W        16     length field width; multiple of 8 in 8..32; sent as LEN_W/8 bytes, MSB byte first
//  MARKER       8'hB6  frame marker byte
//  RAM_TIMEOUT  255    max CLK cycles waiting for RAM_RDY; 0 = no timeout
// PORTS
//  CLK          in   1       system clock; all logic on posedge
//  RESET        in   1       asynchronous, active-low reset
//  TX_STR       in   1       start request; sampled in IDLE only
//  TX_FLAG      in   8       frame flag byte; latched on accepted TX_STR
//  TX_LEN       in   LEN_W   payload byte count; latched on accepted TX_STR
//  TX_BASE      in   ADDR_W  RAM address of the first payload byte; latched on accepted TX_STR
//  ABORT        in   1       synchronous frame abort
//  RAM_REQ      out  1       RAM read request
//  RAM_RDY      in   1       RAM read done; RAM_DATA valid in the same cycle
//  RAM_ADDR     out  ADDR_W  RAM read address
//  RAM_DATA     in   8       RAM read data
//  TX_DATA      out  8       byte to the line coder
//  TX_VALID     out  1       TX_DATA valid
//  TX_READY     in   1       line coder accepts the byte
//  BUSY         out  1       frame in progress
//  DONE         out  1       1-cycle pulse: frame completed normally
//  ERR          out  1       1-cycle pulse: frame ended by abort or RAM timeout
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, CRC register 16'hFFFF.
//  Byte handshake: a byte transfers on the posedge where TX_VALID & TX_READY.
//   - While TX_VALID=1 and TX_READY=0, TX_DATA is held stable.
//   - The next byte may be presented in the cycle after the transfer.
//   - Throughput target: 1 byte/cycle for header bytes with TX_READY held at 1.
//  FSM states and transitions:
//   - IDLE: when TX_STR=1, latch FLAG/LEN/BASE, set BUSY=1, clear CRC to FFFF, go to HDR. TX_VALID asserts the next cycle.
//   - HDR: send MARKER, FLAG, then LEN bytes (MSB first). After the last length byte:
//       LEN==0 -> CRC (or END when the CRC is compiled out);
//       otherwise -> RD with idx=0.
//   - RD: RAM_REQ=1, RAM_ADDR=TX_BASE+idx, modulo 2^ADDR_W wrap. RAM_REQ is held until RAM_RDY.
//       On RAM_RDY: capture the byte, drop RAM_REQ, go to DATA.
//       RAM_RDY outside RD is ignored.
//   - DATA: present the captured byte. On transfer, idx++; idx==LEN -> CRC/END, else -> RD.
//   - CRC: send crc[15:8] then crc[7:0], then go to END.
//   - END: DONE=1 for 1 cycle, BUSY=0, go to IDLE. A new TX_STR is accepted from the next cycle on.
//  CRC16-CCITT:
//   - Polynomial 0x1021, init FFFF, MSB-first, no reflection, no final XOR.
//   - Covers FLAG, length bytes and payload; excludes the marker.
//   - Updated on each accepted byte.
//  Counter widths: idx is LEN_W bits wide. LEN = 2^LEN_W-1 must work without overflow.
//  ABORT (any non-IDLE state, highest priority):
//   - Next cycle: TX_VALID=0, RAM_REQ=0, ERR pulse 1 cycle, BUSY=0, go to IDLE.
//   - A byte handshaking in the same cycle as ABORT counts as sent; it is not retracted.
//  RAM timeout: if RAM_TIMEOUT!=0 and the RD wait exceeds RAM_TIMEOUT cycles, take the abort path (ERR pulse).
//  TX_STR while BUSY is ignored and not queued.
//  Reset mid-frame: everything returns to reset values asynchronously; no DONE/ERR is emitted.
// CONFIGURATION
//  HS_FRAMER_CRC_EN
//   - Defined: CRC state is present; the 2 CRC bytes are appended (frame = 2+LEN_W/8+LEN+2 bytes).
//   - Undefined: no CRC logic; after the last payload/length byte go straight to END (frame = 2+LEN_W/8+LEN bytes).
// TESTING
//  1 LEN_W=16, FLAG=0x5A, LEN=3, BASE=0x0100, RAM bytes 11 22 33, READY=1
//    -> bytes B6 5A 00 03 11 22 33 crcH crcL, reads at 0100..0102, DONE once.
//  2 LEN=0, FLAG=0x01 -> B6 01 00 00 crcH crcL; RAM_REQ never asserted; DONE pulse.
//  3 READY toggles randomly (50%) on scenario 1
//    -> identical byte sequence; TX_DATA stable while VALID & ~READY; CRC matches golden CCITT model.
//  4 RAM_TIMEOUT=8, RAM_RDY never rises on the 2nd byte
//    -> ERR pulse 9 cycles after RAM_REQ rises; RAM_REQ=0, BUSY=0, no DONE.
//  5 ABORT while the 2nd payload byte has VALID=1
//    -> next cycle VALID=0, ERR=1, IDLE; a new TX_STR then sends a full correct frame.
//  6 BASE=0xFFFE, LEN=4 -> RAM_ADDR FFFE FFFF 0000 0001; TX_STR pulsed mid-frame is ignored.

Source files
------------

// File: rtl/mod_hs_packet_framer.sv
// Packet framer: marker, flag, length field, RAM payload and optional CRC16 trailer.
// Optional feature macro: HS_FRAMER_CRC_EN appends the CRC16-CCITT trailer.
module mod_hs_packet_framer #(
    parameter int         ADDR_W      = 16,
    parameter int         LEN_W       = 16,
    parameter logic [7:0] MARKER      = 8'hB6,
    parameter int         RAM_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              TX_STR,
    input  logic [7:0]        TX_FLAG,
    input  logic [LEN_W-1:0]  TX_LEN,
    input  logic [ADDR_W-1:0] TX_BASE,
    input  logic              ABORT,
    output logic              RAM_REQ,
    input  logic              RAM_RDY,
    output logic [ADDR_W-1:0] RAM_ADDR,
    input  logic [7:0]        RAM_DATA,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int         TW       = $clog2(RAM_TIMEOUT + 2);
    localparam logic [2:0] HDR_LAST = 3'(LEN_W / 8 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RD,
        S_DATA,
`ifdef HS_FRAMER_CRC_EN
        S_CRC,
`endif
        S_END
    } state_t;

`ifdef HS_FRAMER_CRC_EN
    localparam state_t S_POST = S_CRC;
`else
    localparam state_t S_POST = S_END;
`endif

    state_t            state, state_nx;
    logic [7:0]        flag_q, dbyte_q;
    logic [LEN_W-1:0]  len_q, idx_q, idx_nx;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        hcnt_q;
    logic [TW-1:0]     tcnt_q;
    logic              err_q, xfer, start, abort_go, timed_out;

    assign xfer      = TX_VALID & TX_READY;
    assign start     = (state == S_IDLE) & TX_STR;
    assign idx_nx    = idx_q + LEN_W'(1);
    assign timed_out = (RAM_TIMEOUT != 0) && (tcnt_q == TW'(RAM_TIMEOUT));

`ifdef HS_FRAMER_CRC_EN
    logic [15:0] crc_q;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        return r;
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            crc_q <= 16'hFFFF;
        else if (start)
            crc_q <= 16'hFFFF;
        else if (xfer && ((state == S_HDR && hcnt_q != 3'd0) || state == S_DATA))
            crc_q <= crc_upd(crc_q, TX_DATA);
    end
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        abort_go = 1'b0;
        unique case (state)
            S_IDLE: if (TX_STR) state_nx = S_HDR;
            S_HDR:
                if (xfer && hcnt_q == HDR_LAST)
                    state_nx = (len_q == '0) ? S_POST : S_RD;
            S_RD:
                if (RAM_RDY) state_nx = S_DATA;
                else if (timed_out) abort_go = 1'b1;
            S_DATA:
                if (xfer) state_nx = (idx_nx == len_q) ? S_POST : S_RD;
`ifdef HS_FRAMER_CRC_EN
            S_CRC: if (xfer && hcnt_q[0]) state_nx = S_END;
`endif
            S_END: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (ABORT && state != S_IDLE && state != S_END)
            abort_go = 1'b1;
        if (abort_go)
            state_nx = S_IDLE;
    end

    // Length bytes go out MSB first by rotating len_q; a full set of rotations restores it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            flag_q  <= '0;
            len_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            hcnt_q  <= '0;
            dbyte_q <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= abort_go;
            if (start) begin
                flag_q <= TX_FLAG;
                len_q  <= TX_LEN;
                base_q <= TX_BASE;
                idx_q  <= '0;
                hcnt_q <= '0;
            end
            if (xfer && state == S_HDR) begin
                hcnt_q <= (hcnt_q == HDR_LAST) ? 3'd0 : hcnt_q + 3'd1;
                if (hcnt_q >= 3'd2)
                    len_q <= (len_q << 8) | (len_q >> (LEN_W - 8));
            end
            if (xfer && state == S_DATA)
                idx_q <= idx_nx;
`ifdef HS_FRAMER_CRC_EN
            if (xfer && state == S_CRC)
                hcnt_q <= hcnt_q + 3'd1;
`endif
            if (state == S_RD) begin
                if (RAM_RDY)
                    dbyte_q <= RAM_DATA;
                tcnt_q <= tcnt_q + TW'(1);
            end else begin
                tcnt_q <= '0;
            end
        end
    end

    always_comb begin
        TX_DATA  = 8'h00;
        TX_VALID = 1'b0;
        unique case (state)
            S_HDR: begin
                TX_VALID = 1'b1;
                if (hcnt_q == 3'd0)      TX_DATA = MARKER;
                else if (hcnt_q == 3'd1) TX_DATA = flag_q;
                else                     TX_DATA = len_q[LEN_W-1 -: 8];
            end
            S_DATA: begin
                TX_VALID = 1'b1;
                TX_DATA  = dbyte_q;
            end
`ifdef HS_FRAMER_CRC_EN
            S_CRC: begin
                TX_VALID = 1'b1;
                TX_DATA  = hcnt_q[0] ? crc_q[7:0] : crc_q[15:8];
            end
`endif
            default: ;
        endcase
    end

    assign RAM_REQ  = (state == S_RD);
    assign RAM_ADDR = RAM_REQ ? base_q + ADDR_W'(idx_q) : '0;
    assign BUSY     = (state != S_IDLE) && (state != S_END);
    assign DONE     = (state == S_END);
    assign ERR      = err_q;

endmodule
